// File: rtl/tdm_demux_if.sv
// Sample-stream and frame-output bundle for tdm_demux.
interface tdm_demux_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);
  localparam int SW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]          din;
  logic                      din_valid;
  logic                      sync;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic                      dout_valid;
  logic [SW-1:0]             slot;
  logic                      locked;
  logic                      err;

  modport master (
    output din, din_valid, sync,
    input  dout, dout_valid, slot, locked, err
  );

  modport slave (
    input  din, din_valid, sync,
    output dout, dout_valid, slot, locked, err
  );
endinterface

// File: rtl/tdm_demux.sv
// Frame-interleaved sample demultiplexer: sync-aligned slot steering into a
// shadow frame, published as a whole frame with a one-cycle strobe.
module tdm_demux_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk) begin
    if (!rst_n)  q <= '0;
    else if (we) q <= d;
  end
endmodule

module tdm_demux #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);
  localparam int SW = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;
  localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state;

  // The last channel never lands in shadow; it goes straight to dout.
  logic [CHANNELS-2:0][WIDTH-1:0] shadow;
  logic [CHANNELS-2:0]            wr_en;

  for (genvar k = 0; k < CHANNELS - 1; k++) begin : g_we
    if (k == 0) begin : g_first
      assign wr_en[k] = bus.din_valid && bus.sync;
    end else begin : g_rest
      assign wr_en[k] = bus.din_valid && !bus.sync && (state == RUN) &&
                        (bus.slot == SW'(k));
    end
  end

  tdm_demux_lane #(.WIDTH(WIDTH)) u_lane [CHANNELS-2:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .d     (bus.din),
    .q     (shadow)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
      bus.slot       <= '0;
      bus.locked     <= 1'b0;
      bus.err        <= 1'b0;
    end else begin
      bus.dout_valid <= 1'b0;
      bus.err        <= 1'b0;
      if (bus.din_valid) begin
        case (state)
          IDLE: begin
            if (bus.sync) begin
              state      <= RUN;
              bus.locked <= 1'b1;
              bus.slot   <= SW'(1);
            end
          end
          RUN: begin
            if (bus.sync) begin
              // Early sync drops the partial frame and restarts at slot 0.
              bus.err  <= (bus.slot != '0);
              bus.slot <= SW'(1);
            end else if (bus.slot == '0) begin
              bus.err    <= 1'b1;
              bus.locked <= 1'b0;
              state      <= IDLE;
            end else if (bus.slot == LAST) begin
              bus.dout       <= {bus.din, shadow};
              bus.dout_valid <= 1'b1;
              bus.slot       <= '0;
            end else begin
              bus.slot <= bus.slot + SW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: doc/tdm_demux.md
# tdm_demux

Time-division demultiplexer: the receiving end of the frame-interleaved sample stream produced by the team's mux-based serializers. It accepts one WIDTH-bit sample per valid cycle, steers each sample to its channel slot using a frame-sync marker and an internal slot counter, and publishes a complete, double-buffered frame of CHANNELS samples with a one-cycle strobe. Framing errors are flagged and the block resynchronizes without needing a reset.

## Interface
- CHANNELS, default 4: samples per frame; legal range is 2 to 16.
- WIDTH, default 8: bits per sample.
- SW, derived, not overridable: $clog2(CHANNELS), with a minimum of 1.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  synchronous, active-low reset, sampled on the clk rising edge.
- din  in  WIDTH  sample data; meaningful only when din_valid=1.
- din_valid  in  1  a sample is presented this cycle.
- sync  in  1  marks the din sample as channel 0 (frame start); ignored when din_valid=0.
- dout  out  CHANNELS*WIDTH  last complete frame; channel k occupies dout[k*WIDTH +: WIDTH].
- dout_valid  out  1  one-cycle strobe, high when dout has just been updated.
- slot  out  SW  index the next accepted sample will be written to.
- locked  out  1  1 while in state RUN.
- err  out  1  one-cycle strobe on a framing error.

## Operation
- A sample is accepted on a rising edge where din_valid=1.
- The shadow register array holds a partial frame. dout is written only when a frame completes.

States:
- IDLE (the reset state): accepted samples with sync=0 are dropped silently. An accepted sample with sync=1 is written to shadow[0], then slot←1 and the block moves to RUN.
- RUN, sample with sync=0 and slot≠0: written to shadow[slot], then slot←slot+1.
- RUN, the sample at slot=CHANNELS-1: on the same edge, dout←{din, shadow[CHANNELS-2:0]}, dout_valid←1, slot←0. The block stays in RUN.
- RUN, sync=1 with slot=0: normal frame start. Written to shadow[0], slot←1.
- RUN, sync=1 with slot≠0 (early sync): err←1 and the partial frame is discarded. dout is unchanged. The sample is written to shadow[0], slot←1, and the block stays in RUN.
- RUN, sync=0 with slot=0 (missing sync): err←1, the sample is dropped, slot stays 0, and the block moves to IDLE.

Other rules:
- din_valid=0: no state change, and no strobes the following cycle.
- Slot arithmetic is SW bits wide. Wrap-around happens only through the explicit reset to 0 at CHANNELS-1, never through natural overflow; this matters when CHANNELS is not a power of two.
- err and dout_valid can never both be 1 in the same cycle.

## Timing
- Reset values: dout=0, dout_valid=0, err=0, slot=0, locked=0. The shadow registers are cleared to 0 and the state is IDLE.
- Reset asserted mid-frame: everything above is restored on that edge and the partial frame is lost. The first sample accepted after rst_n rises is evaluated as in IDLE.
- Latency: dout and dout_valid change on the edge that accepts the last slot. They are visible for the following cycle, so latency is 1 cycle from that sample being presented.
- dout_valid and err are high for exactly one cycle per event.
- dout holds its value between strobes.
- Throughput: one sample per cycle, with no bubbles required between frames. A sync sample may directly follow the last slot.
- locked, slot and err are all registered; none is a combinational function of the inputs.

## Test plan
Directed scenarios, all with CHANNELS=4 and WIDTH=8:
- Reset, then a back-to-back frame: sync+0x11, 0x22, 0x33, 0x44 → dout=0x44332211 and a single dout_valid pulse one cycle after the 0x44 cycle. Then locked=1 and slot=0.
- Samples in IDLE without sync (0xAA, 0xBB) → no err, no dout_valid, locked=0, slot=0. A following sync+0x01 sets locked=1 and slot=1.
- Early sync: sync+0x11, 0x22, then sync+0x55, 0x66, 0x77, 0x88 → err pulses on the second sync. dout stays at the previous value until it becomes 0x88776655.
- Missing sync after a complete frame: next sample 0x99 with sync=0 → err pulses, locked=0, 0x99 is dropped, and dout keeps the last frame.
- Gapped stream: the same frame as the first scenario with din_valid=0 for 3 cycles between each pair of samples → identical dout=0x44332211, with a single pulse.
- Reset mid-frame after 2 samples, then a clean frame of 0x0D0C0B0A → all outputs are 0 after reset, and the next dout=0x0D0C0B0A with no err.
